// File: rtl/logic_sweep_unit.sv
// rtl/logic_sweep_unit.sv - bitwise logic unit with one-stage output register and truth-table sweep generator
//
// Purpose:
//   Evaluates an 8-way bitwise opcode on two WIDTH-bit operands and presents
//   the result, together with the operands, from a single registered output
//   stage (latency 1, full throughput). Optionally, an internal generator
//   walks every combination of SWEEP_W-bit operands through the same datapath
//   so a complete truth table for one opcode can be collected downstream.
//
// Build option:
//   LOGIC_SWEEP_UNIT_SWEEP_EN - when defined, the sweep generator (IDLE/RUN/DONE
//   FSM) is built. When undefined, sweep_start/sweep_op are ignored,
//   sweep_busy/sweep_done/out_last stay 0 and only external operands flow.
//
// Ports:
//   clk, rst               - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      - external operand handshake
//   in_a, in_b, in_op      - external operands and opcode
//   out_valid/out_ready    - result handshake
//   out_y, out_a, out_b    - result and the operands that produced it
//   out_last               - marks the final vector of a sweep
//   sweep_start, sweep_op  - start a sweep with the given opcode
//   sweep_busy, sweep_done - sweep in progress / one-cycle completion pulse
//
// Opcodes: 0 NAND, 1 AND, 2 OR, 3 NOT a, 4 NOR, 5 XOR, 6 XNOR, 7 pass a

module logic_sweep_unit #(
  parameter int WIDTH   = 8,
  parameter int SWEEP_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_last,
  input  logic             sweep_start,
  input  logic [2:0]       sweep_op,
  output logic             sweep_busy,
  output logic             sweep_done
);

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    logic_op = ~(a & b);
      3'd1:    logic_op = a & b;
      3'd2:    logic_op = a | b;
      3'd3:    logic_op = ~a;
      3'd4:    logic_op = ~(a | b);
      3'd5:    logic_op = a ^ b;
      3'd6:    logic_op = ~(a ^ b);
      default: logic_op = a;
    endcase
  endfunction

  // Output stage registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic             out_last_q, out_last_d;

  // The stage can take a new entry when it is empty or being drained this cycle
  logic stage_accept;
  assign stage_accept = !out_valid_q || out_ready;

  // Issue mux: whichever source (external port or sweep generator) feeds the stage
  logic             iss_valid;
  logic [WIDTH-1:0] iss_a;
  logic [WIDTH-1:0] iss_b;
  logic [2:0]       iss_op;
  logic             iss_last;

`ifdef LOGIC_SWEEP_UNIT_SWEEP_EN
  localparam int            CW      = 2 * SWEEP_W;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    in_ready   = 1'b0;
    sweep_busy = 1'b0;
    sweep_done = 1'b0;
    iss_valid  = 1'b0;
    iss_a      = in_a;
    iss_b      = in_b;
    iss_op     = in_op;
    iss_last   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A sweep request wins over an external operand in the same cycle
        in_ready = stage_accept && !sweep_start;
        if (sweep_start) begin
          state_d = S_RUN;
          op_d    = sweep_op;
          cnt_d   = '0;
        end else begin
          iss_valid = in_valid && stage_accept;
        end
      end
      S_RUN: begin
        sweep_busy = 1'b1;
        // Counter high half drives a, low half drives b
        iss_a      = WIDTH'(cnt_q[CW-1:SWEEP_W]);
        iss_b      = WIDTH'(cnt_q[SWEEP_W-1:0]);
        iss_op     = op_q;
        iss_last   = (cnt_q == CNT_MAX);
        // Under backpressure the counter simply waits, so no vector is skipped or repeated
        if (stage_accept) begin
          iss_valid = 1'b1;
          if (cnt_q == CNT_MAX) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        sweep_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end
`else
  logic unused_sweep;
  assign unused_sweep = ^{sweep_start, sweep_op};

  assign in_ready   = stage_accept;
  assign iss_valid  = in_valid && stage_accept;
  assign iss_a      = in_a;
  assign iss_b      = in_b;
  assign iss_op     = in_op;
  assign iss_last   = 1'b0;
  assign sweep_busy = 1'b0;
  assign sweep_done = 1'b0;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_last_d  = out_last_q;
    // Payload only moves when the stage accepts, which keeps it stable under backpressure
    if (stage_accept) begin
      out_valid_d = iss_valid;
      if (iss_valid) begin
        out_y_d    = logic_op(iss_op, iss_a, iss_b);
        out_a_d    = iss_a;
        out_b_d    = iss_b;
        out_last_d = iss_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_logic_sweep_unit.sv
// tb/tb_logic_sweep_unit.sv - self-checking bench for logic_sweep_unit
module tb_logic_sweep_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DUT 1: WIDTH=8, SWEEP_W=1
  logic       in_valid, in_ready, out_valid, out_ready, out_last;
  logic       sweep_start, sweep_busy, sweep_done;
  logic [7:0] in_a, in_b, out_y, out_a, out_b;
  logic [2:0] in_op, sweep_op;

  // DUT 2: WIDTH=8, SWEEP_W=2
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic       b_sweep_start, b_sweep_busy, b_sweep_done;
  logic [7:0] b_in_a, b_in_b, b_out_y, b_out_a, b_out_b;
  logic [2:0] b_in_op, b_sweep_op;

  logic_sweep_unit #(.WIDTH(8), .SWEEP_W(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_a(out_a), .out_b(out_b),
    .out_last(out_last), .sweep_start(sweep_start), .sweep_op(sweep_op),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done)
  );

  logic_sweep_unit #(.WIDTH(8), .SWEEP_W(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_a(b_in_a), .in_b(b_in_b), .in_op(b_in_op),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_y(b_out_y), .out_a(b_out_a), .out_b(b_out_b),
    .out_last(b_out_last), .sweep_start(b_sweep_start), .sweep_op(b_sweep_op),
    .sweep_busy(b_sweep_busy), .sweep_done(b_sweep_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return ~(a & b);
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return ~a;
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  // Expected sweep vector i as {last, a, b, y}
  function automatic logic [24:0] sweep_vec(input int i, input int sw, input logic [2:0] op);
    logic [7:0] a, b;
    a = 8'(i >> sw);
    b = 8'(i & ((1 << sw) - 1));
    return {(i == (1 << (2 * sw)) - 1), a, b, model(op, a, b)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

  vec_t        tbl[12];
  logic [23:0] sb[$];
  logic [24:0] res[$];
  logic [24:0] bres[$];
  logic [23:0] exp24, held;
  logic        hold_pending;
  int          ndone, done_at, last_at;

  initial begin
    tbl[0]  = '{3'd0, 8'hF0, 8'h3C, 8'hCF};
    tbl[1]  = '{3'd1, 8'hF0, 8'h3C, 8'h30};
    tbl[2]  = '{3'd2, 8'hF0, 8'h3C, 8'hFC};
    tbl[3]  = '{3'd3, 8'hF0, 8'h3C, 8'h0F};
    tbl[4]  = '{3'd4, 8'hF0, 8'h3C, 8'h03};
    tbl[5]  = '{3'd5, 8'hF0, 8'h3C, 8'hCC};
    tbl[6]  = '{3'd6, 8'hF0, 8'h3C, 8'h33};
    tbl[7]  = '{3'd7, 8'hF0, 8'h3C, 8'hF0};
    tbl[8]  = '{3'd0, 8'hFF, 8'hFF, 8'h00};
    tbl[9]  = '{3'd5, 8'hAA, 8'h55, 8'hFF};
    tbl[10] = '{3'd4, 8'h00, 8'h00, 8'hFF};
    tbl[11] = '{3'd3, 8'h5A, 8'h00, 8'hA5};

    rst = 1'b1;
    in_valid = 0; in_a = 0; in_b = 0; in_op = 0; out_ready = 1; sweep_start = 0; sweep_op = 0;
    b_in_valid = 0; b_in_a = 0; b_in_b = 0; b_in_op = 0; b_out_ready = 1; b_sweep_start = 0; b_sweep_op = 0;

    // Reset state
    repeat (2) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_out_last", out_last, 0);
    check("rst_sweep_busy", sweep_busy, 0);
    check("rst_sweep_done", sweep_done, 0);
    check("rst_b_out_valid", b_out_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // Table-driven external operands, back-to-back
    for (int i = 0; i < 12; i++) begin
      in_valid = 1; in_a = tbl[i].a; in_b = tbl[i].b; in_op = tbl[i].op;
      @(negedge clk);
      check($sformatf("tbl_in_ready[%0d]", i), in_ready, 1);
      step();
      check($sformatf("tbl_valid[%0d]", i), out_valid, 1);
      check($sformatf("tbl_y[%0d]", i), out_y, tbl[i].y);
      check($sformatf("tbl_ab[%0d]", i), {out_a, out_b}, {tbl[i].a, tbl[i].b});
      check($sformatf("tbl_last[%0d]", i), out_last, 0);
    end
    in_valid = 0;
    step();
    check("tbl_drain", out_valid, 0);

    // Randomized external traffic with random backpressure against a scoreboard
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_op     = 3'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rand_in_ready", in_ready, !out_valid || out_ready);
      check("rand_occupancy", sb.size(), out_valid);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("rand_spurious", 1, 0);
        else begin
          exp24 = sb.pop_front();
          check("rand_out", {out_a, out_b, out_y}, exp24);
        end
      end
      hold_pending = out_valid && !out_ready;
      held = {out_a, out_b, out_y};
      if (in_valid && in_ready) sb.push_back({in_a, in_b, model(in_op, in_a, in_b)});
      step();
      if (hold_pending) check("rand_hold", {out_a, out_b, out_y, out_valid}, {held, 1'b1});
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    if (out_valid) begin
      if (sb.size() == 0) check("drain_spurious", 1, 0);
      else begin
        exp24 = sb.pop_front();
        check("drain_out", {out_a, out_b, out_y}, exp24);
      end
    end
    step();
    check("rand_drain_valid", out_valid, 0);
    check("rand_sb_empty", sb.size(), 0);

`ifdef LOGIC_SWEEP_UNIT_SWEEP_EN
    // Sweep, SWEEP_W=1, NAND; a retrigger and an opcode change during RUN must be ignored
    ndone = 0; done_at = -1; last_at = -1;
    out_ready = 1; sweep_op = 3'd0; sweep_start = 1;
    for (int c = 0; c < 14; c++) begin
      if (c == 1) sweep_op = 3'd5;
      if (c == 2) sweep_start = 0;
      @(negedge clk);
      if (c == 1) begin
        check("sw1_busy", sweep_busy, 1);
        check("sw1_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        res.push_back({out_last, out_a, out_b, out_y});
        if (out_last) last_at = c;
      end
      if (sweep_done) begin ndone++; done_at = c; end
      step();
    end
    check("sw1_count", res.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < res.size()) check($sformatf("sw1_vec[%0d]", i), res[i], sweep_vec(i, 1, 3'd0));
    check("sw1_done_pulses", ndone, 1);
    check("sw1_done_timing", done_at, last_at);
    check("sw1_idle_busy", sweep_busy, 0);

    // Sweep, SWEEP_W=2, XOR, with out_ready toggling
    ndone = 0;
    b_sweep_op = 3'd5; b_sweep_start = 1;
    for (int c = 0; c < 60; c++) begin
      if (c == 1) b_sweep_start = 0;
      b_out_ready = (c % 2 == 0);
      @(negedge clk);
      if (b_out_valid && b_out_ready) bres.push_back({b_out_last, b_out_a, b_out_b, b_out_y});
      if (b_sweep_done) ndone++;
      step();
    end
    b_out_ready = 1;
    check("sw2_count", bres.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < bres.size()) check($sformatf("sw2_vec[%0d]", i), bres[i], sweep_vec(i, 2, 3'd5));
    check("sw2_done_pulses", ndone, 1);

    // sweep_start beats in_valid in IDLE
    in_valid = 1; in_a = 8'hAA; in_b = 8'h55; in_op = 3'd7;
    sweep_start = 1; sweep_op = 3'd2; out_ready = 1;
    @(negedge clk);
    check("prio_in_ready", in_ready, 0);
    step();
    in_valid = 0; sweep_start = 0;
    step();
    check("prio_valid", out_valid, 1);
    check("prio_vec0", {out_last, out_a, out_b, out_y}, sweep_vec(0, 1, 3'd2));
    repeat (10) step();
    check("prio_back_idle", sweep_busy, 0);

    // Reset in the middle of a sweep
    sweep_op = 3'd1; sweep_start = 1; out_ready = 1;
    step();
    sweep_start = 0;
    step();
    step();
    check("mid_vec1", {out_a, out_b}, {8'h00, 8'h01});
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", {out_y, out_a, out_b}, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_busy", sweep_busy, 0);
    check("mid_rst_done", sweep_done, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_in_ready", in_ready, 1);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (sweep_done || out_valid) ndone++;
      step();
    end
    check("mid_no_done", ndone, 0);
`else
    // Sweep disabled: sweep inputs have no effect, external path unchanged
    sweep_start = 1; sweep_op = 3'd3; out_ready = 1;
    b_sweep_start = 1; b_sweep_op = 3'd1;
    for (int i = 5; i < 9; i++) begin
      in_valid = 1; in_a = tbl[i].a; in_b = tbl[i].b; in_op = tbl[i].op;
      @(negedge clk);
      check($sformatf("cfg_in_ready[%0d]", i), in_ready, 1);
      check($sformatf("cfg_busy[%0d]", i), {sweep_busy, b_sweep_busy}, 0);
      check($sformatf("cfg_done[%0d]", i), {sweep_done, b_sweep_done}, 0);
      step();
      check($sformatf("cfg_out[%0d]", i), {out_valid, out_last, out_y}, {1'b1, 1'b0, tbl[i].y});
    end
    in_valid = 0; sweep_start = 0; b_sweep_start = 0;
    step();
    check("cfg_drain", out_valid, 0);
    check("cfg_b_idle", b_out_valid, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_sweep_unit.md
LOGIC_SWEEP_UNIT -- requirements
Module: logic_sweep_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width, 1..32.
REQ-002 SHALL have parameter SWEEP_W, default 1: sweep bits per operand, 1..min(WIDTH,8).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  external operand valid.
REQ-006 SHALL have port in_ready  output  1  stage accepts external operands.
REQ-007 SHALL have ports in_a, in_b  input  WIDTH  operands; in_op  input  3  opcode.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have ports out_y  output  WIDTH  result; out_a, out_b  output  WIDTH  operands echoed with result; out_last  output  1  final sweep vector.
REQ-011 SHALL have port sweep_start  input  1  start truth-table sweep; sweep_op  input  3  sweep opcode.
REQ-012 SHALL have ports sweep_busy  output  1  sweep active; sweep_done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL decode opcode bitwise: 0 NAND, 1 AND, 2 OR, 3 NOT a, 4 NOR, 5 XOR, 6 XNOR, 7 pass a.
REQ-014 SHALL register result, operands and out_last in one output stage: latency exactly 1 cycle from accepted transfer to out_valid.
REQ-015 SHALL define transfer as valid&&ready on either port; stage accepts when !out_valid || out_ready (full throughput, back-to-back).
REQ-016 SHALL hold out_y/out_a/out_b/out_last stable while out_valid=1 and out_ready=0.
REQ-017 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-018 SHALL in IDLE: in_ready = stage accepts && !sweep_start; sweep_start=1 moves to RUN, latches sweep_op, clears counter i (2*SWEEP_W bits).
REQ-019 SHALL give sweep_start priority over in_valid in the same IDLE cycle; the external operand is not accepted that cycle.
REQ-020 SHALL in RUN: in_ready=0, sweep_busy=1; issue a = zero-extended i[2*SWEEP_W-1:SWEEP_W], b = zero-extended i[SWEEP_W-1:0] with latched opcode whenever stage accepts; increment i per issued vector.
REQ-021 SHALL set out_last=1 only on vector i = 2^(2*SWEEP_W)-1; after issuing it move to DONE; counter SHALL NOT wrap to reissue 0.
REQ-022 SHALL in DONE: assert sweep_done for exactly one cycle, sweep_busy=0, in_ready=0, return to IDLE next cycle.
REQ-023 SHALL ignore sweep_start in RUN and DONE; sweep_op changes after start SHALL have no effect.
REQ-024 SHALL stall the sweep under backpressure without skipping or duplicating vectors.

Reset
REQ-025 SHALL on rst, asynchronously: state IDLE, counter 0, out_valid=0, out_y=0, out_a=0, out_b=0, out_last=0, sweep_done=0, latched opcode 0.
REQ-026 SHALL abort a sweep on rst mid-operation with no sweep_done pulse; pending result discarded.
REQ-027 SHALL drive in_ready=1 in the first cycle after rst deasserts with sweep_start=0.

Configuration
REQ-028 SHALL, with LOGIC_SWEEP_UNIT_SWEEP_EN defined, implement REQ-017..REQ-024 as stated.
REQ-029 SHALL, without LOGIC_SWEEP_UNIT_SWEEP_EN, keep all ports, ignore sweep_start and sweep_op, tie sweep_busy=0, sweep_done=0, out_last=0, and set in_ready = stage accepts.

Verification
REQ-030 SHALL cover WIDTH=8, sweep: sweep_op=0, SWEEP_W=1, sweep_start pulse, out_ready=1 -> 4 results, (a,b,y)=(0,0,FF),(0,1,FF),(1,0,FF),(1,1,FE), out_last on 4th only, sweep_done 1 cycle after 4th issue.
REQ-031 SHALL cover external: in_a=F0, in_b=3C, op 0..7 back-to-back -> y = CF,30,FC,0F,03,CC,33,F0, one per cycle, latency 1.
REQ-032 SHALL cover backpressure: SWEEP_W=2, op 5, out_ready toggling 1/0 -> 16 vectors i=0..15 in order, none lost or duplicated, y=a^b.
REQ-033 SHALL cover priority: sweep_start and in_valid asserted together in IDLE -> in_ready=0, external operand not consumed, sweep vector i=0 issued.
REQ-034 SHALL cover reset mid-sweep: rst asserted after 2 of 4 vectors -> all outputs 0 immediately, no sweep_done, in_ready=1 after release.
REQ-035 SHALL cover config: build without LOGIC_SWEEP_UNIT_SWEEP_EN, sweep_start=1 -> sweep_busy=0, sweep_done=0, external transfers unaffected.
